// File: rtl/prold_loader.sv
// Program-load sequencer: assembles little-endian UART bytes into 32-bit words
// and issues one-cycle write orders to the fetch unit, followed by a drain window.
module prold_loader #(
  parameter int LEN_WORD     = 32,
  parameter int LEN_INST     = 32,
  parameter int MAX_WORDS    = 4096,
  parameter int DRAIN_CYCLES = 2
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic                start,
  input  logic                rx_valid,
  input  logic [7:0]          rx_data,
  output logic                prold_mode,
  output logic                prold_order,
  output logic [LEN_WORD-1:0] prold_pc,
  output logic [LEN_INST-1:0] prold_data,
  output logic                busy,
  output logic                load_done,
  output logic                overflow,
  output logic [31:0]         checksum,
  output logic [LEN_WORD-1:0] words_loaded
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LEN   = 3'd1,
    DATA  = 3'd2,
    DRAIN = 3'd3,
    DONE  = 3'd4
  } state_t;

  function automatic logic [31:0] fold_checksum(input logic [31:0] acc, input logic [31:0] word);
    return acc ^ word;
  endfunction

  state_t              state_r, next_state_s;
  logic [31:0]         asm_r;
  logic [1:0]          byte_idx_r;
  logic [LEN_WORD-1:0] len_r;
  logic [LEN_WORD-1:0] words_loaded_r;
  logic [31:0]         checksum_r;
  logic                overflow_r;
  logic                prold_order_r;
  logic [LEN_WORD-1:0] prold_pc_r;
  logic [LEN_INST-1:0] prold_data_r;
  logic [7:0]          drain_cnt_r;
  logic                prold_mode_r, busy_r, load_done_r;

  logic                accept_s, byte_last_s, last_word_s, in_range_s, drain_done_s;
  logic [31:0]         word_s;
  logic [LEN_WORD-1:0] next_count_s;
  logic                mode_nx_s, busy_nx_s, done_nx_s;

  assign accept_s     = rx_valid && ((state_r == LEN) || (state_r == DATA));
  assign byte_last_s  = accept_s && (byte_idx_r == 2'd3);
  assign word_s       = {rx_data, asm_r[31:8]};
  assign next_count_s = words_loaded_r + LEN_WORD'(1);
  assign last_word_s  = (next_count_s == len_r);
  assign in_range_s   = (words_loaded_r < LEN_WORD'(MAX_WORDS));
  // The order cycle of the final word is not part of the drain count.
  assign drain_done_s = (state_r == DRAIN) && !prold_order_r &&
                        (drain_cnt_r == 8'(DRAIN_CYCLES - 1));

  // State register
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state_r <= IDLE;
    else       state_r <= next_state_s;
  end

  // Next-state logic
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      IDLE:    if (start) next_state_s = LEN; else next_state_s = IDLE;
      LEN:     if (byte_last_s) next_state_s = (word_s == 32'd0) ? DRAIN : DATA;
               else next_state_s = LEN;
      DATA:    if (byte_last_s && last_word_s) next_state_s = DRAIN; else next_state_s = DATA;
      DRAIN:   if (drain_done_s) next_state_s = DONE; else next_state_s = DRAIN;
      DONE:    next_state_s = IDLE;
      default: next_state_s = IDLE;
    endcase
  end

  // Status outputs derived from the state being entered, so they register in step with it
  always_comb begin
    mode_nx_s = 1'b0;
    busy_nx_s = 1'b1;
    done_nx_s = 1'b0;
    case (next_state_s)
      IDLE:    busy_nx_s = 1'b0;
      LEN:     mode_nx_s = 1'b1;
      DATA:    mode_nx_s = 1'b1;
      DRAIN:   mode_nx_s = 1'b1;
      DONE:    done_nx_s = 1'b1;
      default: busy_nx_s = 1'b0;
    endcase
  end

  // Byte assembly, word bookkeeping, write orders and registered status
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      asm_r          <= 32'd0;
      byte_idx_r     <= 2'd0;
      len_r          <= '0;
      words_loaded_r <= '0;
      checksum_r     <= 32'd0;
      overflow_r     <= 1'b0;
      prold_order_r  <= 1'b0;
      prold_pc_r     <= '0;
      prold_data_r   <= '0;
      drain_cnt_r    <= 8'd0;
      prold_mode_r   <= 1'b0;
      busy_r         <= 1'b0;
      load_done_r    <= 1'b0;
    end else begin
      prold_order_r <= 1'b0;
      if ((state_r == IDLE) && start) begin
        asm_r          <= 32'd0;
        byte_idx_r     <= 2'd0;
        words_loaded_r <= '0;
        checksum_r     <= 32'd0;
        overflow_r     <= 1'b0;
      end else if (accept_s) begin
        asm_r      <= word_s;
        byte_idx_r <= byte_idx_r + 2'd1;
        if (byte_idx_r == 2'd3) begin
          if (state_r == LEN) begin
            len_r      <= LEN_WORD'(word_s);
            overflow_r <= (LEN_WORD'(word_s) > LEN_WORD'(MAX_WORDS));
          end else begin
            checksum_r     <= fold_checksum(checksum_r, word_s);
            words_loaded_r <= next_count_s;
            if (in_range_s) begin
              prold_order_r <= 1'b1;
              prold_pc_r    <= words_loaded_r << 2;
              prold_data_r  <= LEN_INST'(word_s);
            end
          end
        end
      end
      if (state_r != DRAIN)    drain_cnt_r <= 8'd0;
      else if (!prold_order_r) drain_cnt_r <= drain_cnt_r + 8'd1;
      prold_mode_r <= mode_nx_s;
      busy_r       <= busy_nx_s;
      load_done_r  <= done_nx_s;
    end
  end

  assign prold_mode   = prold_mode_r;
  assign prold_order  = prold_order_r;
  assign prold_pc     = prold_pc_r;
  assign prold_data   = prold_data_r;
  assign busy         = busy_r;
  assign load_done    = load_done_r;
  assign overflow     = overflow_r;
  assign checksum     = checksum_r;
  assign words_loaded = words_loaded_r;

endmodule

// File: tb/tb_prold_loader.sv
// Bench for prold_loader: two instances (full capacity and MAX_WORDS=2) fed the same
// byte streams, checked against a list-of-words model of the expected load.
module tb_prold_loader;

  localparam int DRAIN = 2;
  localparam int MAX1  = 2;

  logic        clk = 1'b0;
  logic        rstn, start, rx_valid;
  logic [7:0]  rx_data;
  logic        mode[2], order[2], busy[2], done[2], ovf[2];
  logic [31:0] pc[2], data[2], cks[2], wl[2];

  int vectors = 0;
  int miscompares = 0;
  logic [31:0] wq[$];
  logic [63:0] oq0[$], oq1[$];

  always #5 clk = ~clk;

  prold_loader #(.MAX_WORDS(4096), .DRAIN_CYCLES(DRAIN)) dut0 (
    .clk(clk), .rstn(rstn), .start(start), .rx_valid(rx_valid), .rx_data(rx_data),
    .prold_mode(mode[0]), .prold_order(order[0]), .prold_pc(pc[0]), .prold_data(data[0]),
    .busy(busy[0]), .load_done(done[0]), .overflow(ovf[0]), .checksum(cks[0]),
    .words_loaded(wl[0]));

  prold_loader #(.MAX_WORDS(MAX1), .DRAIN_CYCLES(DRAIN)) dut1 (
    .clk(clk), .rstn(rstn), .start(start), .rx_valid(rx_valid), .rx_data(rx_data),
    .prold_mode(mode[1]), .prold_order(order[1]), .prold_pc(pc[1]), .prold_data(data[1]),
    .busy(busy[1]), .load_done(done[1]), .overflow(ovf[1]), .checksum(cks[1]),
    .words_loaded(wl[1]));

  // Record every cycle a write order is seen on each instance
  always @(negedge clk) begin
    if (order[0] === 1'b1) oq0.push_back({pc[0], data[0]});
    if (order[1] === 1'b1) oq1.push_back({pc[1], data[1]});
  end

  task automatic drive_cycle(input logic v, input logic [7:0] d, input logic s);
    rx_valid = v;
    rx_data  = d;
    start    = s;
    @(negedge clk);
  endtask

  task automatic run_load(input string name, input bit junk, input bit b2b);
    int n, b0, b1, cnt, exp0, exp1;
    bit seen;
    logic [7:0]  bytes[$];
    logic [31:0] xs;
    logic [63:0] expo;
    n  = wq.size();
    xs = 32'd0;
    for (int i = 0; i < 4; i++) bytes.push_back(8'(n >> (8 * i)));
    foreach (wq[k]) begin
      xs ^= wq[k];
      for (int i = 0; i < 4; i++) bytes.push_back(8'(wq[k] >> (8 * i)));
    end
    b0 = oq0.size();
    b1 = oq1.size();
    if (junk) repeat (3) drive_cycle(1'b1, 8'($urandom), 1'b0);
    drive_cycle(junk, 8'($urandom), 1'b1);
    vectors++;
    if (ovf[1] !== 1'b0 || cks[0] !== 32'd0 || wl[0] !== 32'd0 || mode[0] !== 1'b1 || busy[0] !== 1'b1)
      begin miscompares++;
        $display("FAIL %s start: ovf1=%b cks=%h wl=%0d mode=%b busy=%b, want 0 0 0 1 1",
                 name, ovf[1], cks[0], wl[0], mode[0], busy[0]); end
    foreach (bytes[i]) begin
      if (!b2b) repeat ($urandom_range(0, 2))
        drive_cycle(1'b0, 8'($urandom), junk ? 1'($urandom) : 1'b0);
      drive_cycle(1'b1, bytes[i], junk ? 1'($urandom) : 1'b0);
    end
    seen = 1'b0;
    cnt  = 0;
    for (int c = 0; c < 20 && !seen; c++) begin
      if (done[0] === 1'b1) seen = 1'b1;
      else begin
        if (mode[0] === 1'b1) cnt++;
        drive_cycle(junk ? 1'($urandom) : 1'b0, 8'($urandom), 1'b0);
      end
    end
    vectors++;
    if (!seen) begin miscompares++; $display("FAIL %s load_done: not seen within 20 cycles", name); end
    vectors++;
    if (cnt != ((n > 0) ? DRAIN + 1 : DRAIN)) begin miscompares++;
      $display("FAIL %s drain: %0d mode cycles after last byte, want %0d", name, cnt,
               (n > 0) ? DRAIN + 1 : DRAIN); end
    vectors++;
    if (mode[0] !== 1'b0 || busy[0] !== 1'b1) begin miscompares++;
      $display("FAIL %s done_cycle: mode=%b busy=%b, want 0 1", name, mode[0], busy[0]); end
    drive_cycle(1'b0, 8'h00, 1'b0);
    vectors++;
    if (busy[0] !== 1'b0 || done[0] !== 1'b0) begin miscompares++;
      $display("FAIL %s idle: busy=%b load_done=%b, want 0 0", name, busy[0], done[0]); end
    exp0 = n;
    exp1 = (n < MAX1) ? n : MAX1;
    vectors++;
    if (oq0.size() - b0 != exp0) begin miscompares++;
      $display("FAIL %s orders0: %0d, want %0d", name, oq0.size() - b0, exp0); end
    for (int k = 0; k < exp0 && b0 + k < oq0.size(); k++) begin
      expo = {32'(k * 4), wq[k]};
      vectors++;
      if (oq0[b0 + k] !== expo) begin miscompares++;
        $display("FAIL %s order0[%0d]: pc/data=%h, want %h", name, k, oq0[b0 + k], expo); end
    end
    vectors++;
    if (oq1.size() - b1 != exp1) begin miscompares++;
      $display("FAIL %s orders1: %0d, want %0d", name, oq1.size() - b1, exp1); end
    for (int k = 0; k < exp1 && b1 + k < oq1.size(); k++) begin
      expo = {32'(k * 4), wq[k]};
      vectors++;
      if (oq1[b1 + k] !== expo) begin miscompares++;
        $display("FAIL %s order1[%0d]: pc/data=%h, want %h", name, k, oq1[b1 + k], expo); end
    end
    for (int i = 0; i < 2; i++) begin
      vectors++;
      if (cks[i] !== xs || wl[i] !== 32'(n) || ovf[i] !== ((i == 0) ? 1'b0 : (n > MAX1))) begin
        miscompares++;
        $display("FAIL %s result%0d: cks=%h wl=%0d ovf=%b, want %h %0d %b", name, i, cks[i], wl[i],
                 ovf[i], xs, n, (i == 0) ? 1'b0 : (n > MAX1)); end
    end
  endtask

  task automatic test_reset;
    rstn = 1'b0; start = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      vectors++;
      if ({mode[i], order[i], busy[i], done[i], ovf[i]} !== 5'b0 || pc[i] !== 32'd0 ||
          data[i] !== 32'd0 || cks[i] !== 32'd0 || wl[i] !== 32'd0) begin miscompares++;
        $display("FAIL reset%0d: flags=%b pc=%h data=%h cks=%h wl=%h, want all 0", i,
                 {mode[i], order[i], busy[i], done[i], ovf[i]}, pc[i], data[i], cks[i], wl[i]); end
    end
    rstn = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_single_word;
    wq = '{32'h0000_0013};
    run_load("single", 1'b0, 1'b0);
  endtask

  task automatic test_back_to_back;
    wq = '{32'h1111_1111, 32'h2222_2222, 32'h4444_4444};
    run_load("b2b", 1'b0, 1'b1);
  endtask

  task automatic test_zero_length;
    wq = '{};
    run_load("zero", 1'b0, 1'b0);
  endtask

  task automatic test_overflow;
    wq = '{};
    repeat (3) wq.push_back($urandom);
    run_load("overflow", 1'b0, 1'b1);
  endtask

  task automatic test_reset_midload;
    logic [7:0] b[$];
    b = '{8'd3, 8'd0, 8'd0, 8'd0, 8'h78, 8'h56, 8'h34, 8'h12, 8'hAA, 8'hBB};
    drive_cycle(1'b0, 8'h00, 1'b1);
    foreach (b[i]) drive_cycle(1'b1, b[i], 1'b0);
    rx_valid = 1'b0;
    rstn = 1'b0;
    #1;
    vectors++;
    if ({mode[0], order[0], busy[0], done[0], ovf[0]} !== 5'b0 || pc[0] !== 32'd0 ||
        data[0] !== 32'd0 || cks[0] !== 32'd0 || wl[0] !== 32'd0) begin miscompares++;
      $display("FAIL midreset: flags=%b pc=%h data=%h cks=%h wl=%h, want all 0",
               {mode[0], order[0], busy[0], done[0], ovf[0]}, pc[0], data[0], cks[0], wl[0]); end
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    wq = '{};
    repeat (2) wq.push_back($urandom);
    run_load("after_reset", 1'b0, 1'b0);
  endtask

  task automatic test_junk;
    wq = '{};
    repeat (3) wq.push_back($urandom);
    run_load("junk", 1'b1, 1'b0);
  endtask

  task automatic test_random;
    repeat (5) begin
      wq = '{};
      repeat ($urandom_range(1, 5)) wq.push_back($urandom);
      run_load("random", 1'($urandom), 1'($urandom));
    end
  endtask

  initial begin
    test_reset;
    test_single_word;
    test_back_to_back;
    test_zero_length;
    test_overflow;
    test_reset_midload;
    test_junk;
    test_random;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
